// File: rtl/sensor_pkg.sv
// Shared constants for the sensor display: segment patterns and converter states.
package sensor_pkg;

   // Segment patterns are {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_T     = 7'h07;
   localparam logic [6:0] SEG_H     = 7'h09;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   localparam logic [9:0] SAT_MAX = 10'd999;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_LOAD  = 2'd1,
      CONV_SHIFT = 2'd2,
      CONV_DONE  = 2'd3
   } conv_state_t;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One double-dabble iteration on {bcd[11:0], bin[9:0]}: add 3 to any
   // BCD nibble >= 5, then shift the whole register left by one.
   function automatic logic [21:0] dd_step(input logic [21:0] sr);
      logic [21:0] t;
      t = sr;
      for (int i = 0; i < 3; i++) begin
         if (t[10 + 4*i +: 4] >= 4'd5)
            t[10 + 4*i +: 4] = t[10 + 4*i +: 4] + 4'd3;
      end
      return {t[20:0], 1'b0};
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double-dabble).
//
// state      | meaning
// -----------+------------------------------------------------------
// CONV_IDLE  | waiting for start
// CONV_LOAD  | sample bin into the shift register, clear iteration count
// CONV_SHIFT | 10 add-3/shift iterations
// CONV_DONE  | bcd valid for one cycle; restart at LOAD if a start is pending
module bin2bcd_seq
   import sensor_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   conv_state_t state, state_nxt;
   logic        pending, pending_nxt;
   logic [21:0] sr;
   logic [3:0]  iter;

   // State and pending-flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= CONV_IDLE;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
      end
   end

   // Next state; starts arriving mid-conversion collapse into one pending restart.
   // A start seen in DONE needs no flag: the following LOAD already samples it.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      case (state)
         CONV_IDLE: begin
            if (start) state_nxt = CONV_LOAD;
         end
         CONV_LOAD: begin
            state_nxt = CONV_SHIFT;
            if (start) pending_nxt = 1'b1;
         end
         CONV_SHIFT: begin
            if (iter == 4'd9) state_nxt = CONV_DONE;
            if (start) pending_nxt = 1'b1;
         end
         CONV_DONE: begin
            pending_nxt = 1'b0;
            state_nxt   = (pending || start) ? CONV_LOAD : CONV_IDLE;
         end
         default: state_nxt = CONV_IDLE;
      endcase
   end

   // Shift register and iteration counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sr   <= '0;
         iter <= '0;
      end else if (state == CONV_LOAD) begin
         sr   <= {12'd0, bin};
         iter <= '0;
      end else if (state == CONV_SHIFT) begin
         sr   <= dd_step(sr);
         iter <= iter + 4'd1;
      end
   end

   assign busy = (state != CONV_IDLE);
   assign done = (state == CONV_DONE);
   assign bcd  = sr[21:10];

endmodule

// File: rtl/sensor_display.sv
// Four-digit multiplexed display alternating temperature and humidity pages.
module sensor_display
   import sensor_pkg::*;
#(
   parameter int SCAN_DIV    = 50_000,
   parameter int PAGE_CYCLES = 100_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] temp_data,
   input  logic [15:0] hum_data,
   input  logic        sample_valid,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        page,
   output logic        conv_busy
);

   localparam int SCAN_W = $clog2(SCAN_DIV + 1);
   localparam int PAGE_W = $clog2(PAGE_CYCLES + 1);

   logic [SCAN_W-1:0] scan_cnt;
   logic [PAGE_W-1:0] page_cnt;
   logic              scan_tick, page_tick;
   logic [1:0]        digit, digit_nxt;
   logic [15:0]       temp_q, hum_q, sel;
   logic [9:0]        conv_bin;
   logic [11:0]       conv_bcd, bcd_q;
   logic              conv_done;
   logic [6:0]        seg_nxt;
   logic [3:0]        an_nxt;

   assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign page_tick = (page_cnt == PAGE_W'(PAGE_CYCLES - 1));
   assign digit_nxt = scan_tick ? digit - 2'd1 : digit;

   // Selection uses the registered page/data, so a conversion loaded the cycle
   // after a combined sample+toggle sees the new sample on the new page.
   assign sel      = page ? hum_q : temp_q;
   assign conv_bin = (sel > 16'(SAT_MAX)) ? SAT_MAX : sel[9:0];

   bin2bcd_seq u_bin2bcd (
      .clock (clock),
      .reset (reset),
      .start (sample_valid | page_tick),
      .bin   (conv_bin),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Sample capture and converted-value register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         temp_q <= '0;
         hum_q  <= '0;
         bcd_q  <= '0;
      end else begin
         if (sample_valid) begin
            temp_q <= temp_data;
            hum_q  <= hum_data;
         end
         if (conv_done) bcd_q <= conv_bcd;
      end
   end

   // Page timer: toggle and wrap at terminal count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         page_cnt <= '0;
         page     <= 1'b0;
      end else if (page_tick) begin
         page_cnt <= '0;
         page     <= ~page;
      end else begin
         page_cnt <= page_cnt + PAGE_W'(1);
      end
   end

   // Digit scan timer; the digit index wraps naturally from 0 back to 3.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         scan_cnt <= '0;
         digit    <= 2'd3;
      end else begin
         scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
         digit    <= digit_nxt;
      end
   end

   // Segment pattern for the digit about to be shown, with leading-zero blanking.
   always_comb begin
      seg_nxt = SEG_BLANK;
      case (digit_nxt)
         2'd3: seg_nxt = page ? SEG_H : SEG_T;
         2'd2: seg_nxt = (bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd_q[11:8]);
         2'd1: seg_nxt = (bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg_digit(bcd_q[7:4]);
         2'd0: seg_nxt = seg_digit(bcd_q[3:0]);
         default: seg_nxt = SEG_BLANK;
      endcase
      an_nxt = ~(4'b0001 << digit_nxt);
   end

   // Registered outputs so seg and an always change on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg <= SEG_T;
         an  <= 4'b0111;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: doc/sensor_display.md
SENSOR_DISPLAY -- requirements
Module: sensor_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50_000: clock cycles per digit in the multiplex scan.
REQ-002 SHALL have parameter PAGE_CYCLES, default 100_000_000: clock cycles each page is shown before alternating.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port temp_data, input, 16: temperature, unsigned integer degrees C, from the AHT20 controller.
REQ-006 SHALL have port hum_data, input, 16: relative humidity, unsigned integer %, from the AHT20 controller.
REQ-007 SHALL have port sample_valid, input, 1: one-cycle pulse marking fresh temp_data/hum_data.
REQ-008 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an, output, 4: digit enables, active-low, an[3] leftmost.
REQ-010 SHALL have port page, output, 1: page selector, 0 = temperature, 1 = humidity.
REQ-011 SHALL have port conv_busy, output, 1: high while the BCD converter is not IDLE.

Function
REQ-012 SHALL capture temp_data and hum_data into internal registers on the edge where sample_valid=1.
REQ-013 SHALL start a conversion on sample_valid or on a page toggle, converting the captured value for the current page.
REQ-014 SHALL saturate the selected 16-bit value to 999 before conversion.
REQ-015 SHALL run converter FSM IDLE -> LOAD -> SHIFT (10 iterations, shift-add-3 double-dabble, 10-bit input, 12-bit BCD) -> DONE -> IDLE.
REQ-016 SHALL update the displayed BCD registers only in DONE, exactly 12 cycles after the trigger edge accepted in IDLE.
REQ-017 SHALL, on a trigger while not IDLE, set a pending flag and restart from LOAD on the cycle after DONE; multiple triggers collapse into one.
REQ-018 SHALL toggle page when the page counter reaches PAGE_CYCLES-1, then wrap the counter to 0.
REQ-019 SHALL advance the active digit 3->2->1->0->3 when the scan counter reaches SCAN_DIV-1; exactly one an bit low at a time.
REQ-020 SHALL drive digit 3 with a letter: 't' (seg=7'h07) on page 0, 'H' (seg=7'h09) on page 1.
REQ-021 SHALL drive digits 2..0 with hundreds/tens/units; standard hex-free 0-9 decode (e.g. 0 = 7'h40, 8 = 7'h00).
REQ-022 SHALL blank leading zeros (seg=7'h7F) on digits 2 and 1; digit 0 is always shown.
REQ-023 SHALL register seg and an so that both change on the same edge.
REQ-024 SHALL treat simultaneous sample_valid and page toggle as one trigger, converting the new sample for the new page.

Reset
REQ-025 SHALL, while reset=0, force: converter IDLE, pending=0, conv_busy=0, page=0, counters=0, BCD registers=0, captured data=0, an=4'b0111, seg=7'h07.
REQ-026 SHALL abort any in-flight conversion on reset assertion without updating BCD registers.
REQ-027 SHALL resume scanning from digit 3 on the first edge after reset release.

Structure
REQ-028 SHALL place segment constants (letters, digits 0-9, blank) and converter state encodings in a shared package sensor_pkg.
REQ-029 SHALL implement the double-dabble converter as sub-module bin2bcd_seq with start/busy/done handshake.
REQ-030 SHALL keep scan, page and capture logic in the top module.

Verification
REQ-031 SHALL verify: reset release, temp_data=25, sample_valid pulse -> conv_busy high 12 cycles, digits read "t 25" (digit 2 blank, digit 1 = 7'h24, digit 0 = 7'h12).
REQ-032 SHALL verify: hum_data=100, page toggle (PAGE_CYCLES=64 in bench) -> display "H100", page=1.
REQ-033 SHALL verify: temp_data=16'hFFFF -> saturation, display "t999".
REQ-034 SHALL verify: second sample_valid 5 cycles into a conversion -> pending set, second conversion starts cycle after DONE, final digits show second value.
REQ-035 SHALL verify: SCAN_DIV=4 -> an sequence 0111,1011,1101,1110 repeating every 16 cycles, never two low.
REQ-036 SHALL verify: reset asserted mid-SHIFT -> outputs at REQ-025 values within the same cycle, BCD registers stay 0.
